// File: rtl/fetch_unit.sv
// fetch_unit: IF stage and IF/ID pipeline register for the 5-stage MIPS core.
// Define FETCH_PERF_CNT_EN to build the bubble/redirect performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        pcsrcD,
  input  logic [31:0] pcbranchD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic [31:0] bubble_cnt,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD} fetchState;

  fetchState   state;
  logic        kill;
  logic        redirect;
  logic        deliver;
  logic [31:0] pcPlus4;
  logic [31:0] holdInstr;
  logic [31:0] holdPc4;
  logic [31:0] deliverInstr;
  logic [31:0] deliverPc4;

  assign redirect  = pcsrcD & ~stallD;
  assign pcPlus4   = pcF + 32'd4;
  assign imem_req  = reset_n & (state == ISSUE) & ~stallF & ~redirect;
  assign imem_addr = pcF;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    deliver      = 1'b0;
    deliverInstr = imem_rdata;
    deliverPc4   = pcPlus4;
    case (state)
      WAIT: deliver = imem_rvalid & ~kill & ~stallD & ~redirect;
      HOLD: begin
        deliver      = ~stallD & ~redirect;
        deliverInstr = holdInstr;
        deliverPc4   = holdPc4;
      end
      default: ;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ISSUE;
      kill     <= 1'b0;
      pcF      <= RESET_PC;
      instrD   <= NOP_INSTR;
      pcplus4D <= '0;
      validD   <= 1'b0;
    end else begin
      if (redirect)     pcF <= pcbranchD;
      else if (deliver) pcF <= deliverPc4;

      if (!stallD) begin
        if (deliver) begin
          instrD   <= deliverInstr;
          pcplus4D <= deliverPc4;
          validD   <= 1'b1;
        end else begin
          instrD <= NOP_INSTR;
          validD <= 1'b0;
        end
      end

      case (state)
        ISSUE: if (imem_req) state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            kill <= 1'b0;
            // Stale or redirected data is dropped; a stalled decode parks it in HOLD.
            if (kill || redirect || !stallD) state <= ISSUE;
            else                             state <= HOLD;
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        HOLD:    if (!stallD) state <= ISSUE;
        default: state <= ISSUE;
      endcase
    end
  end

  // NOTE: the hold buffer is datapath only read in HOLD after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == WAIT && imem_rvalid && !kill && stallD) begin
      holdInstr <= imem_rdata;
      holdPc4   <= pcPlus4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt   <= '0;
      redirect_cnt <= '0;
    end else begin
      if (!stallD && !deliver) bubble_cnt <= bubble_cnt + 32'd1;
      if (redirect)            redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`else
  assign bubble_cnt   = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stalls,
// redirects and memory latency, checked by a program-order scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stallF = 1'b0;
  logic        stallD = 1'b0;
  logic        pcsrcD = 1'b0;
  logic [31:0] pcbranchD = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcplus4D;
  logic        validD;
  logic [31:0] bubble_cnt;
  logic [31:0] redirect_cnt;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset_n(reset_n), .stallF(stallF), .stallD(stallD),
    .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
    .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_0008) return 32'h2010_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // Instruction memory: one outstanding read, answered after latFixed cycles (0 = random 1..4).
  int          latFixed = 1;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] pendAddr = '0;

  always @(negedge clk) begin
    if (pend) cnt--;
    if (pend && cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(pendAddr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  // Reference model: decode must see the program in order from the last reset/redirect target.
  logic [31:0] expQ[$];
  logic        edgeReset = 1'b1;
  logic        edgeStallD = 1'b0;
  logic        edgeRedirect = 1'b0;
  logic [31:0] edgeTarget = '0;
  int          deliveries = 0;
  int          modelRedirects = 0;
  int          modelBubbles = 0;

  // Sampler: looks at settled inputs just before each rising edge.
  always @(negedge clk) begin
    #3;
    edgeReset    = !reset_n;
    edgeStallD   = stallD;
    edgeRedirect = reset_n && pcsrcD && !stallD;
    edgeTarget   = pcbranchD;
    if (imem_rvalid) pend = 1'b0;
    if (!reset_n) begin
      expQ.delete();
      expQ.push_back(RESET_PC);
      modelRedirects = 0;
    end else begin
      if (imem_req) begin
        check("req_single_outstanding", 32'(pend), 32'd0);
        check("req_gating", 32'(stallF | edgeRedirect), 32'd0);
        if (expQ.size() > 0) check("req_addr", imem_addr, expQ[0]);
        pend     = 1'b1;
        cnt      = (latFixed > 0) ? latFixed : int'($urandom_range(1, 4));
        pendAddr = imem_addr;
      end
      if (edgeRedirect) begin
        expQ.delete();
        expQ.push_back(pcbranchD);
        modelRedirects++;
      end
    end
  end

  // Monitor: checks the IF/ID register after each edge against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] pc;
    if (edgeReset) begin
      check("reset_validD", 32'(validD), 32'd0);
      check("reset_instrD", instrD, NOP_INSTR);
      check("reset_pcF", pcF, RESET_PC);
      modelBubbles = 0;
    end else if (!edgeStallD) begin
      if (edgeRedirect) begin
        check("redirect_validD", 32'(validD), 32'd0);
        check("redirect_instrD", instrD, NOP_INSTR);
        check("redirect_pcF", pcF, edgeTarget);
        modelBubbles++;
      end else if (validD) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL delivery: got instr %08h, want no delivery", instrD);
        end else begin
          pc = expQ.pop_front();
          expQ.push_back(pc + 32'd4);
          check("deliver_instrD", instrD, memWord(pc));
          check("deliver_pcplus4D", pcplus4D, pc + 32'd4);
          check("deliver_pcF", pcF, pc + 32'd4);
          deliveries++;
        end
      end else begin
        modelBubbles++;
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int w;
    repeat (2) nxt();
    check("rst_pcF", pcF, RESET_PC);
    check("rst_validD", 32'(validD), 32'd0);
    check("rst_instrD", instrD, NOP_INSTR);
    check("rst_pcplus4D", pcplus4D, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);

    // Latency 1, no stalls: fetch 0,4,8 with a delivery every second cycle.
    reset_n = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      check("t1_validD", 32'(validD), 32'((k >= 2) && (k % 2 == 0)));
      check("t1_pcF", pcF, 32'(4 * (k / 2)));
      if (k >= 2 && k % 2 == 0) check("t1_instrD", instrD, memWord(32'(4 * (k / 2 - 1))));
      #1;
      check("t1_req", 32'(imem_req), 32'(k % 2 == 0));
      if (k % 2 == 0) check("t1_addr", imem_addr, 32'(4 * (k / 2)));
      if (k < 6) nxt();
    end

    // Latency 3, decode stalls on the cycle the word at pc 8 returns.
    pcsrcD = 1'b1; pcbranchD = 32'h8; latFixed = 3;
    nxt();
    pcsrcD = 1'b0;
    check("t2_pcF", pcF, 32'h8);
    #1;
    check("t2_req", 32'(imem_req), 32'd1);
    check("t2_addr", imem_addr, 32'h8);
    w = 0;
    do begin nxt(); w++; end while (!imem_rvalid && w < 10);
    check("t2_rvalid_in_time", 32'(w < 10), 32'd1);
    stallF = 1'b1; stallD = 1'b1;
    for (int k = 0; k < 2; k++) begin
      nxt();
      check("t2_hold_instrD", instrD, NOP_INSTR);
      check("t2_hold_validD", 32'(validD), 32'd0);
      check("t2_hold_pcF", pcF, 32'h8);
    end
    stallF = 1'b0; stallD = 1'b0;
    nxt();
    check("t2_rel_instrD", instrD, 32'h2010_0005);
    check("t2_rel_pcplus4D", pcplus4D, 32'd12);
    check("t2_rel_pcF", pcF, 32'd12);
    check("t2_rel_validD", 32'(validD), 32'd1);

    // Redirect to 0x40 while waiting on 0x10; the stale word must be dropped.
    pcsrcD = 1'b1; pcbranchD = 32'h10;
    nxt();
    pcsrcD = 1'b0;
    #1;
    check("t3_req10", 32'(imem_req), 32'd1);
    check("t3_addr10", imem_addr, 32'h10);
    nxt();
    pcsrcD = 1'b1; pcbranchD = 32'h40;
    #1;
    check("t3_req_redirect", 32'(imem_req), 32'd0);
    nxt();
    pcsrcD = 1'b0;
    check("t3_pcF", pcF, 32'h40);
    check("t3_bubble", 32'(validD), 32'd0);
    #1;
    check("t3_no_req_kill1", 32'(imem_req), 32'd0);
    nxt();
    #1;
    check("t3_no_req_kill2", 32'(imem_req), 32'd0);
    nxt();
    #1;
    check("t3_req40", 32'(imem_req), 32'd1);
    check("t3_addr40", imem_addr, 32'h40);
    w = 0;
    do begin nxt(); w++; end while (!validD && w < 12);
    check("t3_instrD", instrD, memWord(32'h40));
    check("t3_pcplus4D", pcplus4D, 32'h44);

    // Branch asserted under stall is deferred until the stall lifts.
    stallF = 1'b1; stallD = 1'b1; pcsrcD = 1'b1; pcbranchD = 32'h80; latFixed = 4;
    #1;
    check("t4_req_stalled", 32'(imem_req), 32'd0);
    for (int k = 0; k < 2; k++) begin
      nxt();
      check("t4_pcF_held", pcF, 32'h44);
      check("t4_instrD_held", instrD, memWord(32'h40));
      check("t4_validD_held", 32'(validD), 32'd1);
    end
    stallF = 1'b0; stallD = 1'b0;
    #1;
    check("t4_req_redirect", 32'(imem_req), 32'd0);
    nxt();
    pcsrcD = 1'b0;
    check("t4_pcF", pcF, 32'h80);
    check("t4_validD", 32'(validD), 32'd0);
    #1;
    check("t4_req80", 32'(imem_req), 32'd1);
    check("t4_addr80", imem_addr, 32'h80);

    // Asynchronous reset while waiting; the late response must be ignored.
    nxt();
    reset_n = 1'b0;
    #1;
    check("t5_pcF", pcF, RESET_PC);
    check("t5_validD", 32'(validD), 32'd0);
    check("t5_instrD", instrD, NOP_INSTR);
    check("t5_pcplus4D", pcplus4D, 32'd0);
    check("t5_req", 32'(imem_req), 32'd0);
    check("t5_bubble_cnt", bubble_cnt, 32'd0);
    check("t5_redirect_cnt", redirect_cnt, 32'd0);
    nxt();
    reset_n = 1'b1; stallF = 1'b1; stallD = 1'b1;
    repeat (3) nxt();
    nxt();
    check("t5_late_pcF", pcF, RESET_PC);
    check("t5_late_validD", 32'(validD), 32'd0);
    stallF = 1'b0; stallD = 1'b0;
    #1;
    check("t5_req", 32'(imem_req), 32'd1);
    check("t5_addr", imem_addr, RESET_PC);

    // Randomized stalls, redirects (including the wrap point) and latency.
    latFixed = 0;
    for (int k = 0; k < 1500; k++) begin
      nxt();
      stallF    = ($urandom % 5) == 0;
      stallD    = stallF;
      pcsrcD    = ($urandom % 10) == 0;
      pcbranchD = (($urandom % 6) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_03FF);
    end
    stallF = 1'b0; stallD = 1'b0; pcsrcD = 1'b0;
    repeat (12) nxt();
    check("progress", 32'(deliveries > 100), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("bubble_cnt", bubble_cnt, 32'(modelBubbles));
    check("redirect_cnt", redirect_cnt, 32'(modelRedirects));
`else
    check("bubble_cnt_off", bubble_cnt, 32'd0);
    check("redirect_cnt_off", redirect_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
